vector_store_unit: RTL and testbench

Drains a vector register group to data memory for unit-stride vector stores. Takes a store command (source register group, element width, LMUL, VL, base address) and reads the group one 32-bit register at a time through a dedicated register-file read port. It issues one word-wide write per register over a req/gnt memory interface, with byte enables trimmed on the final beat. It sits between the vector register file and the core's data memory port, and is the store-direction counterpart of the load write-back path.

---
 rtl/vector_store_unit_if.sv | 36 +++
 rtl/vector_store_unit.sv | 215 +++++++++++++++++++++
 tb/tb_vector_store_unit.sv | 266 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/vector_store_unit_if.sv
// rtl/vector_store_unit_if.sv - data memory write port bundle for vector_store_unit
//
// Purpose: groups the req/gnt data memory write signals of the vector store unit.
// Signals:
//   data_req    request valid (master -> slave)
//   data_we     write enable, always 1 from the store unit (master -> slave)
//   data_addr   32-bit word-aligned beat address (master -> slave)
//   data_be     4-bit byte enables (master -> slave)
//   data_wdata  32-bit write data (master -> slave)
//   data_gnt    request accepted this cycle (slave -> master)
interface vector_store_unit_if;
  logic        data_req;
  logic        data_we;
  logic [31:0] data_addr;
  logic [3:0]  data_be;
  logic [31:0] data_wdata;
  logic        data_gnt;

  modport master (
    output data_req,
    output data_we,
    output data_addr,
    output data_be,
    output data_wdata,
    input  data_gnt
  );

  modport slave (
    input  data_req,
    input  data_we,
    input  data_addr,
    input  data_be,
    input  data_wdata,
    output data_gnt
  );
endinterface

// File: rtl/vector_store_unit.sv
// rtl/vector_store_unit.sv - unit-stride vector store: drains a register group to data memory
//
// Purpose: latches a store command, reads the source register group one 32-bit
// register at a time and writes one word per register over a req/gnt port,
// trimming byte enables on the final beat.
// Optional feature macro: VSTORE_PREFETCH_EN (read of register k+1 overlaps the
// request of beat k, giving back-to-back beats). Undefined: FETCH cycle per beat.
// Ports:
//   clk, n_reset         clock, asynchronous active-low reset
//   start                command strobe, sampled only in IDLE
//   vs3_addr, vsew, vlmul, vl, base_addr   command fields
//   busy, done, err      status (done/err are one-cycle pulses)
//   reg_rd_addr, reg_rd_data   register-file read port (combinational data)
//   mem                  data memory write port (master side)
module vector_store_unit #(
  parameter int VLEN = 32
) (
  input  logic            clk,
  input  logic            n_reset,
  input  logic            start,
  input  logic [4:0]      vs3_addr,
  input  logic [1:0]      vsew,
  input  logic [1:0]      vlmul,
  input  logic [4:0]      vl,
  input  logic [31:0]     base_addr,
  output logic            busy,
  output logic            done,
  output logic            err,
  output logic [4:0]      reg_rd_addr,
  input  logic [VLEN-1:0] reg_rd_data,
  vector_store_unit_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE,
    S_FETCH,
    S_REQ,
    S_DONE
  } state_t;

  state_t state_q, state_nxt;

  // Latched command
  logic [4:0]  grp_q;
  logic [4:0]  nbytes_q;
  logic [31:0] base_q;
  logic        err_q;
  logic [1:0]  k_q;

  // Beat output registers
  logic [31:0] addr_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;

  logic        req_c;

  // Command decode (only meaningful while IDLE)
  logic [4:0]  vlmax;
  logic [4:0]  eff_vl;
  logic [4:0]  nbytes_cmd;
  logic [4:0]  lmul_mask;
  logic [4:0]  grp_cmd;
  logic        cmd_bad;

  always_comb begin
    vlmax      = (5'd4 >> vsew) << vlmul;
    eff_vl     = (vl < vlmax) ? vl : vlmax;
    nbytes_cmd = eff_vl << vsew;
    lmul_mask  = (5'd1 << vlmul) - 5'd1;
    grp_cmd    = vs3_addr & ~lmul_mask;
    cmd_bad    = (vsew == 2'd3) || (vlmul == 2'd3) || (base_addr[1:0] != 2'b00);
  end

  // Beat bookkeeping: rem is the byte count still to be written from beat k on.
  logic [1:0]  k_nxt;
  logic [4:0]  rem;
  logic        last;

  assign k_nxt = k_q + 2'd1;
  assign rem   = nbytes_q - {1'b0, k_q, 2'b00};
  assign last  = (rem <= 5'd4);

`ifdef VSTORE_PREFETCH_EN
  logic [4:0]  rem_nxt;
  assign rem_nxt = nbytes_q - {1'b0, k_nxt, 2'b00};
`endif

  function automatic logic [3:0] be_mask(input logic [4:0] r);
    logic [3:0] m;
    if (r >= 5'd4) begin
      m = 4'b1111;
    end else begin
      case (r[1:0])
        2'd3:    m = 4'b0111;
        2'd2:    m = 4'b0011;
        2'd1:    m = 4'b0001;
        default: m = 4'b0000;
      endcase
    end
    return m;
  endfunction

  // State register
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_nxt;
    end
  end

  // Next state and control outputs
  always_comb begin
    state_nxt   = state_q;
    busy        = 1'b1;
    done        = 1'b0;
    err         = 1'b0;
    req_c       = 1'b0;
    reg_rd_addr = 5'd0;
    case (state_q)
      S_IDLE: begin
        busy = 1'b0;
        if (start) begin
          if (cmd_bad || (nbytes_cmd == 5'd0)) begin
            state_nxt = S_DONE;
          end else begin
            state_nxt = S_FETCH;
          end
        end
      end
      S_FETCH: begin
        reg_rd_addr = grp_q | {3'b000, k_q};
        state_nxt   = S_REQ;
      end
      S_REQ: begin
        req_c = 1'b1;
`ifdef VSTORE_PREFETCH_EN
        // Present the next register while this beat waits for its grant.
        if (!last) begin
          reg_rd_addr = grp_q | {3'b000, k_nxt};
        end
`endif
        if (mem.data_gnt) begin
          if (last) begin
            state_nxt = S_DONE;
          end else begin
`ifdef VSTORE_PREFETCH_EN
            state_nxt = S_REQ;
`else
            state_nxt = S_FETCH;
`endif
          end
        end
      end
      S_DONE: begin
        done      = 1'b1;
        err       = err_q;
        state_nxt = S_IDLE;
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Command latch and beat datapath
  always_ff @(posedge clk or negedge n_reset) begin
    if (!n_reset) begin
      grp_q    <= 5'd0;
      nbytes_q <= 5'd0;
      base_q   <= 32'd0;
      err_q    <= 1'b0;
      k_q      <= 2'd0;
      addr_q   <= 32'd0;
      be_q     <= 4'd0;
      wdata_q  <= 32'd0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            grp_q    <= grp_cmd;
            nbytes_q <= nbytes_cmd;
            base_q   <= base_addr;
            err_q    <= cmd_bad;
            k_q      <= 2'd0;
          end
        end
        S_FETCH: begin
          wdata_q <= reg_rd_data;
          addr_q  <= base_q + {28'd0, k_q, 2'b00};
          be_q    <= be_mask(rem);
        end
        S_REQ: begin
          if (mem.data_gnt && !last) begin
            k_q <= k_nxt;
`ifdef VSTORE_PREFETCH_EN
            wdata_q <= reg_rd_data;
            addr_q  <= base_q + {28'd0, k_nxt, 2'b00};
            be_q    <= be_mask(rem_nxt);
`endif
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign mem.data_req   = req_c;
  assign mem.data_we    = 1'b1;
  assign mem.data_addr  = addr_q;
  assign mem.data_be    = be_q;
  assign mem.data_wdata = wdata_q;

endmodule

// File: tb/tb_vector_store_unit.sv
// tb/tb_vector_store_unit.sv - directed self-checking bench for vector_store_unit
module tb_vector_store_unit;

  logic        clk;
  logic        n_reset;
  logic        start;
  logic [4:0]  vs3_addr;
  logic [1:0]  vsew;
  logic [1:0]  vlmul;
  logic [4:0]  vl;
  logic [31:0] base_addr;
  logic        busy;
  logic        done;
  logic        err;
  logic [4:0]  reg_rd_addr;
  logic [31:0] reg_rd_data;
  logic [31:0] rf [32];

  vector_store_unit_if mem_if ();

  vector_store_unit #(.VLEN(32)) dut (
    .clk         (clk),
    .n_reset     (n_reset),
    .start       (start),
    .vs3_addr    (vs3_addr),
    .vsew        (vsew),
    .vlmul       (vlmul),
    .vl          (vl),
    .base_addr   (base_addr),
    .busy        (busy),
    .done        (done),
    .err         (err),
    .reg_rd_addr (reg_rd_addr),
    .reg_rd_data (reg_rd_data),
    .mem         (mem_if)
  );

  assign reg_rd_data = rf[reg_rd_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // Results of the last run
  int          nbeats;
  int          nreq;
  int          done_cyc;
  logic        err_seen;
  logic [4:0]  rd_c1;
  int          unstable;
  int          drops;
  logic [31:0] b_addr [8];
  logic [31:0] b_data [8];
  logic [3:0]  b_be   [8];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Issue one command and act as the memory slave until done (bounded).
  task automatic run(input logic [4:0] vs3, input logic [1:0] sew, input logic [1:0] lmul,
                     input logic [4:0] vlen, input logic [31:0] base,
                     input int stall_beat, input int stall_len, input bit pulse_mid);
    logic        prev_req;
    logic        prev_gnt;
    int          wait_cnt;
    logic [31:0] h_addr;
    logic [31:0] h_data;
    logic [3:0]  h_be;
    nbeats = 0; nreq = 0; done_cyc = -1; err_seen = 1'b0; rd_c1 = 5'd0;
    unstable = 0; drops = 0;
    prev_req = 1'b0; prev_gnt = 1'b0; wait_cnt = 0;
    h_addr = 32'd0; h_data = 32'd0; h_be = 4'd0;
    @(negedge clk);
    vs3_addr = vs3; vsew = sew; vlmul = lmul; vl = vlen; base_addr = base;
    start = 1'b1;
    for (int cyc = 1; cyc <= 60; cyc++) begin
      @(negedge clk);
      if (cyc == 1) begin
        start = 1'b0;
        rd_c1 = reg_rd_addr;
      end
      if (pulse_mid && cyc == 2) begin
        start = 1'b1;
        base_addr = 32'h0000_0102;
        vl = 5'd0;
      end
      if (cyc == 3) start = 1'b0;
      if (mem_if.data_req) begin
        nreq++;
        if (!prev_req || prev_gnt) begin
          h_addr = mem_if.data_addr; h_data = mem_if.data_wdata; h_be = mem_if.data_be;
          wait_cnt = 0;
        end else if (h_addr !== mem_if.data_addr || h_data !== mem_if.data_wdata ||
                     h_be !== mem_if.data_be) begin
          unstable++;
        end
        if (nbeats == stall_beat && wait_cnt < stall_len) begin
          mem_if.data_gnt = 1'b0;
          wait_cnt++;
        end else begin
          mem_if.data_gnt = 1'b1;
          if (nbeats < 8) begin
            b_addr[nbeats] = mem_if.data_addr;
            b_data[nbeats] = mem_if.data_wdata;
            b_be[nbeats]   = mem_if.data_be;
          end
          nbeats++;
        end
      end else begin
        if (prev_req && !prev_gnt) drops++;
        mem_if.data_gnt = 1'b0;
      end
      prev_req = mem_if.data_req;
      prev_gnt = mem_if.data_gnt;
      if (done) begin
        done_cyc = cyc;
        err_seen = err;
        break;
      end
    end
    mem_if.data_gnt = 1'b0;
    start = 1'b0;
  endtask

  int exp_t2_done;
  int idle_hits;
  int wait_req;

  initial begin
`ifdef VSTORE_PREFETCH_EN
    exp_t2_done = 4;
`else
    exp_t2_done = 5;
`endif
    for (int i = 0; i < 32; i++) rf[i] = 32'h5A00_0000 | 32'(i);
    rf[4]  = 32'hDDCC_BBAA;
    rf[8]  = 32'h2222_1111;
    rf[9]  = 32'h4444_3333;
    rf[12] = 32'hC0C0_0012;
    rf[13] = 32'hC1C1_0013;
    rf[14] = 32'hC2C2_0014;
    rf[15] = 32'hC3C3_0015;
    n_reset = 1'b0; start = 1'b0; vs3_addr = 5'd0; vsew = 2'd0; vlmul = 2'd0;
    vl = 5'd0; base_addr = 32'd0; mem_if.data_gnt = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_ctrl", {26'd0, busy, done, err, mem_if.data_req, 2'b00}, 32'd0);
    check("rst_rd_be", {23'd0, reg_rd_addr, mem_if.data_be}, 32'd0);
    check("rst_addr", mem_if.data_addr, 32'd0);
    check("rst_wdata", mem_if.data_wdata, 32'd0);
    check("rst_we", {31'd0, mem_if.data_we}, 32'd1);
    @(negedge clk);
    n_reset = 1'b1;

    // T1: single full beat
    run(5'd4, 2'd0, 2'd0, 5'd4, 32'h100, -1, 0, 1'b0);
    check("t1_rd_c1", {27'd0, rd_c1}, 32'd4);
    check("t1_beats", 32'(nbeats), 32'd1);
    check("t1_addr", b_addr[0], 32'h100);
    check("t1_data", b_data[0], 32'hDDCC_BBAA);
    check("t1_be", {28'd0, b_be[0]}, 32'hF);
    check("t1_done_cyc", 32'(done_cyc), 32'd3);
    check("t1_err", {31'd0, err_seen}, 32'd0);

    // T2: 16-bit elements, two beats with trimmed tail
    run(5'd8, 2'd1, 2'd1, 5'd3, 32'h200, -1, 0, 1'b0);
    check("t2_beats", 32'(nbeats), 32'd2);
    check("t2_b0", {b_addr[0][15:0], 12'd0, b_be[0]}, {16'h0200, 12'd0, 4'hF});
    check("t2_d0", b_data[0], 32'h2222_1111);
    check("t2_b1", {b_addr[1][15:0], 12'd0, b_be[1]}, {16'h0204, 12'd0, 4'h3});
    check("t2_d1", b_data[1], 32'h4444_3333);
    check("t2_done_cyc", 32'(done_cyc), 32'(exp_t2_done));

    // T3: 4 beats with a 3-cycle grant stall on beat 1
    run(5'd12, 2'd2, 2'd2, 5'd4, 32'h0, 1, 3, 1'b0);
    check("t3_done_seen", {31'd0, done_cyc > 0}, 32'd1);
    check("t3_beats", 32'(nbeats), 32'd4);
    check("t3_req_cycles", 32'(nreq), 32'd7);
    check("t3_unstable", 32'(unstable), 32'd0);
    check("t3_drops", 32'(drops), 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t3_addr%0d", i), b_addr[i], 32'(4 * i));
      check($sformatf("t3_data%0d", i), b_data[i], rf[12 + i]);
      check($sformatf("t3_be%0d", i), {28'd0, b_be[i]}, 32'hF);
    end

    // T4a: vl = 0
    run(5'd4, 2'd0, 2'd0, 5'd0, 32'h100, -1, 0, 1'b0);
    check("t4a_done_cyc", 32'(done_cyc), 32'd1);
    check("t4a_err", {31'd0, err_seen}, 32'd0);
    check("t4a_req", 32'(nreq), 32'd0);

    // T4b: misaligned base
    run(5'd4, 2'd0, 2'd0, 5'd4, 32'h102, -1, 0, 1'b0);
    check("t4b_done_cyc", 32'(done_cyc), 32'd1);
    check("t4b_err", {31'd0, err_seen}, 32'd1);
    check("t4b_req", 32'(nreq), 32'd0);

    // T5: vl clamped to 16 bytes, odd vs3 aligned down, start pulsed while busy
    run(5'd13, 2'd0, 2'd2, 5'd20, 32'h40, -1, 0, 1'b1);
    check("t5_beats", 32'(nbeats), 32'd4);
    check("t5_err", {31'd0, err_seen}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("t5_addr%0d", i), b_addr[i], 32'h40 + 32'(4 * i));
      check($sformatf("t5_data%0d", i), b_data[i], rf[12 + i]);
      check($sformatf("t5_be%0d", i), {28'd0, b_be[i]}, 32'hF);
    end
    idle_hits = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (busy || done || mem_if.data_req) idle_hits++;
    end
    check("t5_idle_after", 32'(idle_hits), 32'd0);

    // T7: 3-byte tail enables
    run(5'd4, 2'd0, 2'd0, 5'd3, 32'h20, -1, 0, 1'b0);
    check("t7_beats", 32'(nbeats), 32'd1);
    check("t7_be", {28'd0, b_be[0]}, 32'h7);
    check("t7_data", b_data[0], 32'hDDCC_BBAA);

    // T8: vsew = 3 is an error
    run(5'd4, 2'd3, 2'd0, 5'd4, 32'h100, -1, 0, 1'b0);
    check("t8_done_cyc", 32'(done_cyc), 32'd1);
    check("t8_err", {31'd0, err_seen}, 32'd1);
    check("t8_req", 32'(nreq), 32'd0);

    // T6: reset asserted while a request is pending
    @(negedge clk);
    vs3_addr = 5'd4; vsew = 2'd2; vlmul = 2'd0; vl = 5'd1; base_addr = 32'h300;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_req = 0;
    while (!mem_if.data_req && wait_req < 10) begin
      @(negedge clk);
      wait_req++;
    end
    check("t6_req_reached", {31'd0, mem_if.data_req}, 32'd1);
    n_reset = 1'b0;
    #1;
    check("t6_rst_ctrl", {26'd0, busy, done, err, mem_if.data_req, 2'b00}, 32'd0);
    check("t6_rst_rd_be", {23'd0, reg_rd_addr, mem_if.data_be}, 32'd0);
    check("t6_rst_addr", mem_if.data_addr, 32'd0);
    check("t6_rst_wdata", mem_if.data_wdata, 32'd0);
    @(negedge clk);
    n_reset = 1'b1;
    run(5'd8, 2'd2, 2'd0, 5'd1, 32'h180, -1, 0, 1'b0);
    check("t6_beats", 32'(nbeats), 32'd1);
    check("t6_addr", b_addr[0], 32'h180);
    check("t6_data", b_data[0], 32'h2222_1111);
    check("t6_be", {28'd0, b_be[0]}, 32'hF);
    check("t6_done_cyc", 32'(done_cyc), 32'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
